mem_stage_dcache: RTL and testbench
===================================

// Module: mem_stage_dcache
// PURPOSE
//  Direct-mapped, write-through, no-write-allocate data cache for the MEM stage.
//  Serves lw/sw from EX/MEM; drives `hit` to the MEM/WB register, which loads only while hit=1.
//  Misses and all stores go to a backing word memory over a req/ack handshake.
// PARAMETERS
//  INDEX_BITS  4   line index width; 2**INDEX_BITS one-word lines; tag = addr[31:INDEX_BITS+2]
// PORTS
//  clk        in   1   single clock, rising-edge logic
//  reset      in   1   synchronous, active-high
//  memRead    in   1   load request; held stable by pipeline while hit=0
//  memWrite   in   1   store request; held stable while hit=0
//  addr       in   32  byte address; [1:0] ignored (word aligned)
//  writeData  in   32  store data
//  readData   out  32  load data, valid when hit=1 and memRead=1
//  hit        out  1   1 = access complete / no access; 0 = stall
//  memReq     out  1   backing-memory request, held until memAck
//  memWe      out  1   1 = write, 0 = read; valid while memReq=1
//  memAddr    out  32  word address {addr[31:2],2'b00}
//  memWData   out  32  = writeData during write request
//  memRData   in   32  read data, valid with memAck
//  memAck     in   1   one-cycle completion pulse; ignored when memReq=0
// BEHAVIOUR
//  Storage: valid[L], tag[L], data[L]; L = 2**INDEX_BITS.
//  Reset: all valid cleared; state IDLE; memReq=0, memWe=0; readData=0; hit=1.
//  Reset mid-op: abandon any transfer; memReq drops next cycle; a late memAck is ignored.
//  States: IDLE, RD_MISS, FILL, WR_THRU.
//  IDLE:
//   - no access -> hit=1, stay.
//   - memRead and tag match with valid=1 -> hit=1 same cycle, readData=data[idx] (0 extra latency).
//   - memRead miss -> hit=0; go to RD_MISS.
//   - memWrite (write wins if both set) -> hit=0; go to WR_THRU.
//  RD_MISS:
//   - memReq=1, memWe=0, hit=0.
//   - on memAck: data[idx]=memRData, tag[idx]=tag, valid[idx]=1; go to FILL.
//  FILL:
//   - memReq=0; hit=1; readData=data[idx]; go to IDLE next cycle.
//   - Miss latency = 1 + ack delay + 1 cycles.
//  WR_THRU:
//   - memReq=1, memWe=1; hit=memAck (completes in the ack cycle).
//   - on memAck: if tag hit, data[idx]=writeData (write-update); else cache unchanged; go to IDLE.
//   - Store to a valid line with a different tag: no invalidate, no allocate.
//  hit is Moore-plus-lookup combinational:
//   - never 1 in RD_MISS, nor in WR_THRU before memAck.
//  memAddr/memWData come from the held request inputs; they need no internal latch.
//  readData holds its last value when hit=0 or on a store.
//  Index wrap: addresses differing only above the index alias to one line; last fill wins.
// CONFIGURATION
//  DCACHE_STATS_EN defined: adds ports
//   - hitCount out 32: +1 on each IDLE read hit.
//   - missCount out 32: +1 on each RD_MISS entry.
//   - Both saturate at 32'hFFFF_FFFF; both clear on reset.
//  DCACHE_STATS_EN undefined: ports and counters absent; behaviour otherwise identical.
// TESTING
//  1 reset, then lw 0x40, ack after 3 cycles with 0xDEADBEEF -> memReq high 3 cycles, hit=1 in FILL, readData=0xDEADBEEF.
//  2 repeat lw 0x40 -> hit=1 same cycle, readData=0xDEADBEEF, memReq stays 0.
//  3 sw 0x40 data 0x12345678, ack after 2 cycles -> memWe=1, hit=1 only in ack cycle; then lw 0x40 hits, returns 0x12345678.
//  4 lw 0x440 (same index as 0x40, tag differs) -> miss, refill; then lw 0x40 misses again (conflict eviction).
//  5 assert reset while in RD_MISS, then pulse memAck -> memReq=0, ack ignored, next lw 0x40 misses (valid cleared).
//  6 DCACHE_STATS_EN: scenarios 1,2,4 -> hitCount=1, missCount=3; memRead&memWrite together -> treated as store.

Source files
------------

// File: rtl/mem_stage_dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache for the MEM stage.
// Optional hit/miss statistics ports are enabled by defining DCACHE_STATS_EN.
module mem_stage_dcache #(
    parameter int INDEX_BITS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [31:0] addr,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        hit,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [31:0] memWData,
    input  logic [31:0] memRData,
`ifdef DCACHE_STATS_EN
    input  logic        memAck,
    output logic [31:0] hitCount,
    output logic [31:0] missCount
`else
    input  logic        memAck
`endif
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 32 - INDEX_BITS - 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        FILL    = 2'd2,
        WR_THRU = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [LINES-1:0] r_valid;
    logic [TAG_W-1:0] r_tag  [LINES];
    logic [31:0]      r_data [LINES];
    logic [31:0]      r_readData;

    logic [INDEX_BITS-1:0] w_idx;
    logic [TAG_W-1:0]      w_tag;
    logic                  w_tagHit;
    logic                  w_readHit;
    logic                  w_readMiss;
    logic                  w_unused;

    assign w_idx    = addr[INDEX_BITS+1:2];
    assign w_tag    = addr[31:INDEX_BITS+2];
    assign w_unused = ^addr[1:0];

    assign w_tagHit   = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    // Write wins when both requests are raised, so a read only counts without memWrite.
    assign w_readHit  = (r_state == IDLE) && memRead && !memWrite && w_tagHit;
    assign w_readMiss = (r_state == IDLE) && memRead && !memWrite && !w_tagHit;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        hit    = 1'b0;
        memReq = 1'b0;
        memWe  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (memWrite) begin
                    w_next = WR_THRU;
                end else if (memRead && !w_tagHit) begin
                    w_next = RD_MISS;
                end else begin
                    hit = 1'b1;
                end
            end
            RD_MISS: begin
                memReq = 1'b1;
                if (memAck) begin
                    w_next = FILL;
                end
            end
            FILL: begin
                hit    = 1'b1;
                w_next = IDLE;
            end
            WR_THRU: begin
                memReq = 1'b1;
                memWe  = 1'b1;
                hit    = memAck;
                if (memAck) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
        end else if (r_state == RD_MISS && memAck) begin
            r_valid[w_idx] <= 1'b1;
        end
    end

    // Tag/data need no reset; a reset coinciding with an ack must not fill the line.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (r_state == RD_MISS && memAck) begin
                r_tag[w_idx]  <= w_tag;
                r_data[w_idx] <= memRData;
            end else if (r_state == WR_THRU && memAck && w_tagHit) begin
                r_data[w_idx] <= writeData;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_readData <= '0;
        end else if (w_readHit || r_state == FILL) begin
            r_readData <= r_data[w_idx];
        end
    end

    assign readData = (w_readHit || r_state == FILL) ? r_data[w_idx] : r_readData;
    assign memAddr  = {addr[31:2], 2'b00};
    assign memWData = writeData;

`ifdef DCACHE_STATS_EN
    logic [31:0] r_hitCount;
    logic [31:0] r_missCount;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hitCount  <= '0;
            r_missCount <= '0;
        end else begin
            if (w_readHit && r_hitCount != '1) begin
                r_hitCount <= r_hitCount + 32'd1;
            end
            if (w_readMiss && r_missCount != '1) begin
                r_missCount <= r_missCount + 32'd1;
            end
        end
    end

    assign hitCount  = r_hitCount;
    assign missCount = r_missCount;
`else
    logic w_unusedMiss;
    assign w_unusedMiss = w_readMiss;
`endif

endmodule

// File: tb/tb_mem_stage_dcache.sv
// Directed bench for mem_stage_dcache: miss/fill, hit, write-through, conflict, reset abort.
// Stats checks are included when DCACHE_STATS_EN is defined.
module tb_mem_stage_dcache;

    logic        clk;
    logic        reset;
    logic        memRead;
    logic        memWrite;
    logic [31:0] addr;
    logic [31:0] writeData;
    logic [31:0] readData;
    logic        hit;
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [31:0] memWData;
    logic [31:0] memRData;
    logic        memAck;
`ifdef DCACHE_STATS_EN
    logic [31:0] hitCount;
    logic [31:0] missCount;
`endif

    int n_vec;
    int n_err;

    mem_stage_dcache #(.INDEX_BITS(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .memRead   (memRead),
        .memWrite  (memWrite),
        .addr      (addr),
        .writeData (writeData),
        .readData  (readData),
        .hit       (hit),
        .memReq    (memReq),
        .memWe     (memWe),
        .memAddr   (memAddr),
        .memWData  (memWData),
        .memRData  (memRData),
`ifdef DCACHE_STATS_EN
        .memAck    (memAck),
        .hitCount  (hitCount),
        .missCount (missCount)
`else
        .memAck    (memAck)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then step clear of it before driving/sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        reset     = 1'b1;
        memRead   = 1'b0;
        memWrite  = 1'b0;
        addr      = '0;
        writeData = '0;
        memRData  = '0;
        memAck    = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_hit", {31'd0, hit}, 32'd1);
        chk("rst_req", {31'd0, memReq}, 32'd0);
        chk("rst_we", {31'd0, memWe}, 32'd0);
        chk("rst_rdata", readData, 32'h0);

        // 1: cold miss on 0x40, ack in the third request cycle
        memRead = 1'b1;
        addr    = 32'h40;
        #1;
        chk("s1_idle_hit", {31'd0, hit}, 32'd0);
        tick();
        chk("s1_req1", {31'd0, memReq}, 32'd1);
        chk("s1_we1", {31'd0, memWe}, 32'd0);
        chk("s1_hit1", {31'd0, hit}, 32'd0);
        chk("s1_addr", memAddr, 32'h40);
        tick();
        chk("s1_req2", {31'd0, memReq}, 32'd1);
        tick();
        chk("s1_req3", {31'd0, memReq}, 32'd1);
        memAck   = 1'b1;
        memRData = 32'hDEADBEEF;
        #1;
        chk("s1_hit_ack", {31'd0, hit}, 32'd0);
        tick();
        memAck = 1'b0;
        #1;
        chk("s1_fill_req", {31'd0, memReq}, 32'd0);
        chk("s1_fill_hit", {31'd0, hit}, 32'd1);
        chk("s1_fill_rdata", readData, 32'hDEADBEEF);

        // 2: repeat load hits in the same cycle
        tick();
        chk("s2_hit", {31'd0, hit}, 32'd1);
        chk("s2_rdata", readData, 32'hDEADBEEF);
        chk("s2_req", {31'd0, memReq}, 32'd0);
`ifdef DCACHE_STATS_EN
        chk("s2_hitcnt", hitCount, 32'd0);
        chk("s2_misscnt", missCount, 32'd1);
`endif

        // 3: store 0x40 updates line via write-through, ack after two cycles
        tick();
        memRead   = 1'b0;
        memWrite  = 1'b1;
        writeData = 32'h12345678;
        #1;
        chk("s3_idle_hit", {31'd0, hit}, 32'd0);
        chk("s3_idle_req", {31'd0, memReq}, 32'd0);
        tick();
        chk("s3_req", {31'd0, memReq}, 32'd1);
        chk("s3_we", {31'd0, memWe}, 32'd1);
        chk("s3_hit_wait", {31'd0, hit}, 32'd0);
        chk("s3_wdata", memWData, 32'h12345678);
        tick();
        memAck = 1'b1;
        #1;
        chk("s3_hit_ack", {31'd0, hit}, 32'd1);
        chk("s3_rdata_hold", readData, 32'hDEADBEEF);
        tick();
        memAck   = 1'b0;
        memWrite = 1'b0;
        memRead  = 1'b1;
        #1;
        chk("s3_lw_hit", {31'd0, hit}, 32'd1);
        chk("s3_lw_rdata", readData, 32'h12345678);

        // 4: 0x440 aliases to index 0 with another tag, evicting 0x40
        tick();
        addr = 32'h440;
        #1;
        chk("s4_miss", {31'd0, hit}, 32'd0);
        tick();
        chk("s4_req", {31'd0, memReq}, 32'd1);
        chk("s4_addr", memAddr, 32'h440);
        memAck   = 1'b1;
        memRData = 32'hCAFEF00D;
        tick();
        memAck = 1'b0;
        #1;
        chk("s4_fill_hit", {31'd0, hit}, 32'd1);
        chk("s4_fill_rdata", readData, 32'hCAFEF00D);
        tick();
        addr = 32'h40;
        #1;
        chk("s4_evict_miss", {31'd0, hit}, 32'd0);
        chk("s4_rdata_hold", readData, 32'hCAFEF00D);
        tick();
        chk("s4_refill_req", {31'd0, memReq}, 32'd1);
        memAck   = 1'b1;
        memRData = 32'h12345678;
        tick();
        memAck = 1'b0;
        #1;
        chk("s4_refill_rdata", readData, 32'h12345678);
`ifdef DCACHE_STATS_EN
        chk("s4_hitcnt", hitCount, 32'd2);
        chk("s4_misscnt", missCount, 32'd3);
`endif

        // Store miss with both requests raised: treated as store, no allocate
        tick();
        memRead   = 1'b1;
        memWrite  = 1'b1;
        addr      = 32'h440;
        writeData = 32'h55555555;
        #1;
        chk("sm_idle_hit", {31'd0, hit}, 32'd0);
        tick();
        chk("sm_we", {31'd0, memWe}, 32'd1);
        chk("sm_req", {31'd0, memReq}, 32'd1);
        memAck = 1'b1;
        #1;
        chk("sm_hit_ack", {31'd0, hit}, 32'd1);
        tick();
        memAck   = 1'b0;
        memWrite = 1'b0;
        addr     = 32'h40;
        #1;
        chk("sm_line_kept_hit", {31'd0, hit}, 32'd1);
        chk("sm_line_kept_rdata", readData, 32'h12345678);

        // 5: reset during RD_MISS abandons the transfer and clears valid
        tick();
        addr = 32'h44;
        #1;
        chk("s5_miss", {31'd0, hit}, 32'd0);
        tick();
        chk("s5_req", {31'd0, memReq}, 32'd1);
        reset = 1'b1;
        tick();
        reset    = 1'b0;
        memRead  = 1'b0;
        memAck   = 1'b1;
        memRData = 32'hBADBAD00;
        #1;
        chk("s5_req_drop", {31'd0, memReq}, 32'd0);
        chk("s5_rdata_rst", readData, 32'h0);
        tick();
        memAck = 1'b0;
        #1;
        chk("s5_late_ack_req", {31'd0, memReq}, 32'd0);
        memRead = 1'b1;
        addr    = 32'h40;
        #1;
        chk("s5_lw_miss", {31'd0, hit}, 32'd0);
`ifdef DCACHE_STATS_EN
        chk("s5_hitcnt", hitCount, 32'd0);
        chk("s5_misscnt", missCount, 32'd0);
`endif
        tick();
        chk("s5_lw_req", {31'd0, memReq}, 32'd1);
        chk("s5_lw_we", {31'd0, memWe}, 32'd0);
        memAck   = 1'b1;
        memRData = 32'h0000ABCD;
        tick();
        memAck = 1'b0;
        #1;
        chk("s5_fill_rdata", readData, 32'h0000ABCD);
        tick();
        memRead = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
